// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - two-byte UART command frame decoder with valid/ready command output
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout while waiting for the address byte)

module uart_cmd_decoder #(
   parameter int MAX_ADDR       = 31,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_data_ready,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_code,
   output logic [4:0] cmd_addr,
   output logic       err_valid,
   output logic [1:0] err_code,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GOT_CMD = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam logic [7:0] CMD_LAST  = 8'h06;
   localparam logic [7:0] ADDR_LAST = 8'(MAX_ADDR);

   localparam logic [1:0] ERR_TIMEOUT = 2'b00;
   localparam logic [1:0] ERR_BADCMD  = 2'b01;
   localparam logic [1:0] ERR_BADADDR = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   state_t     r_state;
   logic       r_cmd_valid;
   logic [7:0] r_cmd_code;
   logic [4:0] r_cmd_addr;
   logic       r_err_valid;
   logic [1:0] r_err_code;
   logic       r_busy;

   logic       w_cmd_legal;
   logic       w_addr_legal;

`ifdef CMD_TIMEOUT_EN
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
   logic [23:0] r_tmo_cnt;
`endif

   assign w_cmd_legal  = (rx_data <= CMD_LAST);
   assign w_addr_legal = (rx_data <= ADDR_LAST);

   // Frame FSM: every output is a register updated alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cmd_valid <= 1'b0;
         r_cmd_code  <= 8'h00;
         r_cmd_addr  <= 5'd0;
         r_err_valid <= 1'b0;
         r_err_code  <= 2'b00;
         r_busy      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         r_tmo_cnt   <= 24'd0;
`endif
      end else begin
         // errors are single-cycle strobes; a new cause re-asserts below
         r_err_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rx_data_ready) begin
                  if (w_cmd_legal) begin
                     r_cmd_code <= rx_data;
                     r_state    <= GOT_CMD;
                     r_busy     <= 1'b1;
`ifdef CMD_TIMEOUT_EN
                     r_tmo_cnt  <= 24'd0;
`endif
                  end else begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_BADCMD;
                  end
               end
            end
            GOT_CMD: begin
               if (rx_data_ready) begin
                  if (w_addr_legal) begin
                     r_cmd_addr  <= rx_data[4:0];
                     r_cmd_valid <= 1'b1;
                     r_state     <= HOLD;
                  end else begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_BADADDR;
                     r_state     <= IDLE;
                     r_busy      <= 1'b0;
                  end
               end
`ifdef CMD_TIMEOUT_EN
               // an address strobe on the expiry cycle takes priority over the timeout
               else if (r_tmo_cnt == TMO_LAST) begin
                  r_err_valid <= 1'b1;
                  r_err_code  <= ERR_TIMEOUT;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 24'd1;
               end
`endif
            end
            HOLD: begin
               // bytes arriving while a command is pending are dropped, even on the handshake cycle
               if (rx_data_ready) begin
                  r_err_valid <= 1'b1;
                  r_err_code  <= ERR_OVERRUN;
               end
               if (cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_code  = r_cmd_code;
   assign cmd_addr  = r_cmd_addr;
   assign err_valid = r_err_valid;
   assign err_code  = r_err_code;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder (honours CMD_TIMEOUT_EN)

module tb_uart_cmd_decoder;

   localparam int TMO = 100;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       strb;
   logic       rdy;

   logic       v31, ev31, b31;
   logic [7:0] c31;
   logic [4:0] a31;
   logic [1:0] ec31;
   logic       v0, ev0, b0;
   logic [7:0] c0;
   logic [4:0] a0;
   logic [1:0] ec0;

   int n_cmp;
   int n_fail;

   uart_cmd_decoder #(.MAX_ADDR(31), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(din), .rx_data_ready(strb),
      .cmd_valid(v31), .cmd_ready(rdy), .cmd_code(c31), .cmd_addr(a31),
      .err_valid(ev31), .err_code(ec31), .busy(b31)
   );

   uart_cmd_decoder #(.MAX_ADDR(0), .TIMEOUT_CYCLES(TMO)) dut0 (
      .clk(clk), .rst_n(rst_n), .rx_data(din), .rx_data_ready(strb),
      .cmd_valid(v0), .cmd_ready(rdy), .cmd_code(c0), .cmd_addr(a0),
      .err_valid(ev0), .err_code(ec0), .busy(b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         s;
      logic [7:0] d;
      bit         r;
      bit         v;
      logic [7:0] c;
      logic [4:0] a;
      bit         ev;
      logic [1:0] ec;
      bit         b;
   } vec_t;

   vec_t tbl[19];

   // reference model state: index 0 = MAX_ADDR 31, index 1 = MAX_ADDR 0
   bit         m_pend[2];
   int         m_nbytes[2];
   logic [7:0] m_first[2];
   logic [7:0] m_code[2];
   logic [4:0] m_addr[2];
   bit         m_ev[2];
   logic [1:0] m_ec[2];
   int         m_wait[2];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input int idx, input int k, input bit v, input logic [7:0] c,
                          input logic [4:0] a, input bit ev, input logic [1:0] ec, input bit b);
      logic av, aev, ab;
      logic [7:0] ac;
      logic [4:0] aa;
      logic [1:0] aec;
      if (k == 0) begin
         av = v31; ac = c31; aa = a31; aev = ev31; aec = ec31; ab = b31;
      end else begin
         av = v0; ac = c0; aa = a0; aev = ev0; aec = ec0; ab = b0;
      end
      chk({nm, ".cmd_valid"}, idx, 32'(av), 32'(v));
      chk({nm, ".err_valid"}, idx, 32'(aev), 32'(ev));
      chk({nm, ".busy"}, idx, 32'(ab), 32'(b));
      if (v) begin
         chk({nm, ".cmd_code"}, idx, 32'(ac), 32'(c));
         chk({nm, ".cmd_addr"}, idx, 32'(aa), 32'(a));
      end
      if (ev) chk({nm, ".err_code"}, idx, 32'(aec), 32'(ec));
   endtask

   task automatic step(input bit s, input logic [7:0] d, input bit r);
      strb = s;
      din  = d;
      rdy  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      strb  = 1'b0;
      rdy   = 1'b0;
      din   = 8'h00;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_nbytes[k] = 0; m_ev[k] = 0; m_wait[k] = 0;
         m_first[k] = 8'h00; m_code[k] = 8'h00; m_addr[k] = 5'd0; m_ec[k] = 2'b00;
      end
   endtask

   // frame-level behaviour for one clock edge given the inputs presented before it
   task automatic model_step(input int k, input int maxa, input bit s, input logic [7:0] d, input bit r);
      m_ev[k] = 0;
      if (m_pend[k]) begin
         if (s) begin m_ev[k] = 1; m_ec[k] = 2'b11; end
         if (r) m_pend[k] = 0;
      end else if (m_nbytes[k] == 0) begin
         if (s) begin
            if (int'(d) <= 6) begin
               m_nbytes[k] = 1; m_first[k] = d; m_wait[k] = 0;
            end else begin
               m_ev[k] = 1; m_ec[k] = 2'b01;
            end
         end
      end else begin
         if (s) begin
            if (int'(d) <= maxa) begin
               m_pend[k] = 1; m_code[k] = m_first[k]; m_addr[k] = d[4:0];
            end else begin
               m_ev[k] = 1; m_ec[k] = 2'b10;
            end
            m_nbytes[k] = 0;
         end
`ifdef CMD_TIMEOUT_EN
         else begin
            m_wait[k] = m_wait[k] + 1;
            if (m_wait[k] == TMO) begin
               m_ev[k] = 1; m_ec[k] = 2'b00; m_nbytes[k] = 0;
            end
         end
`endif
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      strb   = 1'b0;
      rdy    = 1'b0;
      din    = 8'h00;
      rst_n  = 1'b0;

      //            s  d      r  v  c      a      ev ec     b
      tbl[0]  = '{1, 8'h01, 1, 0, 8'h00, 5'd0,  0, 2'd0, 1};
      tbl[1]  = '{1, 8'h05, 1, 1, 8'h01, 5'd5,  0, 2'd0, 1};
      tbl[2]  = '{0, 8'h00, 1, 0, 8'h00, 5'd0,  0, 2'd0, 0};
      tbl[3]  = '{0, 8'h00, 1, 0, 8'h00, 5'd0,  0, 2'd0, 0};
      tbl[4]  = '{1, 8'h07, 0, 0, 8'h00, 5'd0,  1, 2'd1, 0};
      tbl[5]  = '{0, 8'h00, 0, 0, 8'h00, 5'd0,  0, 2'd0, 0};
      tbl[6]  = '{1, 8'h02, 0, 0, 8'h00, 5'd0,  0, 2'd0, 1};
      tbl[7]  = '{1, 8'h00, 0, 1, 8'h02, 5'd0,  0, 2'd0, 1};
      tbl[8]  = '{0, 8'h00, 0, 1, 8'h02, 5'd0,  0, 2'd0, 1};
      tbl[9]  = '{0, 8'h00, 1, 0, 8'h00, 5'd0,  0, 2'd0, 0};
      tbl[10] = '{1, 8'h03, 0, 0, 8'h00, 5'd0,  0, 2'd0, 1};
      tbl[11] = '{1, 8'h20, 0, 0, 8'h00, 5'd0,  1, 2'd2, 0};
      tbl[12] = '{0, 8'h00, 0, 0, 8'h00, 5'd0,  0, 2'd0, 0};
      tbl[13] = '{1, 8'h04, 0, 0, 8'h00, 5'd0,  0, 2'd0, 1};
      tbl[14] = '{1, 8'h1F, 0, 1, 8'h04, 5'd31, 0, 2'd0, 1};
      tbl[15] = '{1, 8'h06, 0, 1, 8'h04, 5'd31, 1, 2'd3, 1};
      tbl[16] = '{0, 8'h00, 0, 1, 8'h04, 5'd31, 0, 2'd0, 1};
      tbl[17] = '{1, 8'h06, 1, 0, 8'h00, 5'd0,  1, 2'd3, 0};
      tbl[18] = '{0, 8'h00, 0, 0, 8'h00, 5'd0,  0, 2'd0, 0};

      // reset values while rst_n is held low
      #1;
      chk("rst.cmd_code", 0, 32'(c31), 32'h0);
      chk("rst.cmd_addr", 0, 32'(a31), 32'h0);
      chk("rst.err_code", 0, 32'(ec31), 32'h0);
      chk_out("rst", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].d, tbl[i].r);
         chk_out("tbl", i, 0, tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].ev, tbl[i].ec, tbl[i].b);
      end

      // long hold with an overrun byte injected mid-wait
      do_reset();
      step(1, 8'h04, 0);
      step(1, 8'h1F, 0);
      chk_out("hold.start", 0, 0, 1, 8'h04, 5'd31, 0, 2'd0, 1);
      for (int i = 0; i < 50; i++) begin
         step(i == 20, 8'h06, 0);
         chk_out("hold.wait", i, 0, 1, 8'h04, 5'd31, i == 20, 2'd3, 1);
      end
      step(0, 8'h00, 1);
      chk_out("hold.done", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);

      // MAX_ADDR = 0 instance: address 0 accepted, address 1 rejected
      do_reset();
      step(1, 8'h03, 0);
      step(1, 8'h00, 0);
      chk_out("max0.acc", 0, 1, 1, 8'h03, 5'd0, 0, 2'd0, 1);
      step(0, 8'h00, 1);
      chk_out("max0.ack", 0, 1, 0, 8'h00, 5'd0, 0, 2'd0, 0);
      step(1, 8'h03, 0);
      step(1, 8'h01, 0);
      chk_out("max0.rej", 0, 1, 0, 8'h00, 5'd0, 1, 2'd2, 0);
      step(0, 8'h00, 1);
      chk_out("max0.idle", 0, 1, 0, 8'h00, 5'd0, 0, 2'd0, 0);

      // command byte followed by silence
      do_reset();
      step(1, 8'h00, 0);
`ifdef CMD_TIMEOUT_EN
      for (int i = 1; i < TMO; i++) begin
         step(0, 8'h00, 0);
         chk_out("tmo.wait", i, 0, 0, 8'h00, 5'd0, 0, 2'd0, 1);
      end
      step(0, 8'h00, 0);
      chk_out("tmo.fire", TMO, 0, 0, 8'h00, 5'd0, 1, 2'd0, 0);
      step(0, 8'h00, 0);
      chk_out("tmo.after", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);
`else
      for (int i = 1; i <= TMO + 50; i++) begin
         step(0, 8'h00, 0);
         chk_out("notmo.wait", i, 0, 0, 8'h00, 5'd0, 0, 2'd0, 1);
      end
      step(1, 8'h09, 0);
      chk_out("notmo.addr", 0, 0, 1, 8'h00, 5'd9, 0, 2'd0, 1);
      step(0, 8'h00, 1);
`endif

      // asynchronous reset while a command is pending
      do_reset();
      step(1, 8'h01, 0);
      step(1, 8'h02, 0);
      chk_out("arst.hold", 0, 0, 1, 8'h01, 5'd2, 0, 2'd0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.cmd_code", 0, 32'(c31), 32'h0);
      chk("arst.cmd_addr", 0, 32'(a31), 32'h0);
      chk_out("arst.low", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);
      step(1, 8'h01, 0);
      chk_out("arst.ignored", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);
      strb  = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 1);
         chk_out("arst.rel", i, 0, 0, 8'h00, 5'd0, 0, 2'd0, 0);
      end
      step(1, 8'h05, 0);
      chk_out("arst.first", 0, 0, 0, 8'h00, 5'd0, 0, 2'd0, 1);
      step(1, 8'h0A, 0);
      chk_out("arst.frame", 0, 0, 1, 8'h05, 5'd10, 0, 2'd0, 1);
      step(0, 8'h00, 1);

      // randomized traffic against the frame-level model, both instances
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit         s, r;
         logic [7:0] d;
         int         sel;
         s   = ($urandom_range(0, 2) == 0);
         r   = ($urandom_range(0, 1) == 1);
         sel = $urandom_range(0, 3);
         if (sel == 0)      d = 8'h00;
         else if (sel == 1) d = 8'($urandom_range(0, 8));
         else if (sel == 2) d = 8'($urandom_range(0, 40));
         else               d = 8'($urandom_range(0, 255));
         model_step(0, 31, s, d, r);
         model_step(1, 0, s, d, r);
         step(s, d, r);
         chk_out("rnd31", i, 0, m_pend[0], m_code[0], m_addr[0], m_ev[0], m_ec[0],
                 m_pend[0] || (m_nbytes[0] != 0));
         chk_out("rnd0", i, 1, m_pend[1], m_code[1], m_addr[1], m_ev[1], m_ec[1],
                 m_pend[1] || (m_nbytes[1] != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
